text_overlay_writer: RTL and testbench
======================================

TEXT_OVERLAY_WRITER -- requirements
Module: text_overlay_writer

Interface
Parameters:
REQ-001 NUM_CHAR, 300, number of character cells.
REQ-002 COLUMNS, 16, cells per text row; ROWS = ceil(NUM_CHAR/COLUMNS), derived.
REQ-003 CHAR_W, 8, bits per character code.
REQ-004 ATTR_W, 4, bits per cell attribute (colour index); used only with TEXT_OVERLAY_ATTR_EN.
Ports:
REQ-005 i_clk  in  1  sole clock; all logic on rising edge.
REQ-006 i_rst  in  1  reset, synchronous, active-high.
REQ-007 i_characters  in  NUM_CHAR*CHAR_W  cell k at bits [CHAR_W*(NUM_CHAR-1-k) +: CHAR_W]; cell 0 in the MSBs.
REQ-008 i_force  in  1  pulse; request rewrite of every cell regardless of change.
REQ-009 o_wr_valid  out  1  write request to the character buffer.
REQ-010 i_wr_ready  in  1  buffer accepts the write when o_wr_valid && i_wr_ready.
REQ-011 o_wr_char  out  CHAR_W  character code of the write.
REQ-012 o_wr_x  out  $clog2(COLUMNS)  column of the write, k % COLUMNS.
REQ-013 o_wr_y  out  $clog2(ROWS)  row of the write, k / COLUMNS.
REQ-014 o_busy  out  1  high while a scan is in progress.
REQ-015 o_rd_dv  out  1  high when the buffer holds the last scanned snapshot and no scan is pending.

Function
REQ-016 The block SHALL hold a shadow copy (NUM_CHAR*CHAR_W) of what has been written to the buffer, plus a snapshot register and a force flag.
REQ-017 FSM states: IDLE, SCAN, WRITE, DONE.
REQ-018 IDLE -> SCAN when i_characters != shadow or the force flag is set; on this edge, snapshot <= i_characters, index <= 0, o_busy <= 1, o_rd_dv <= 0.
REQ-019 SCAN evaluates one cell per cycle: if snapshot[k] != shadow[k] or force is set, it registers o_wr_char/x/y, sets o_wr_valid, and enters WRITE; otherwise it increments k.
REQ-020 SCAN with an unchanged cell at k = NUM_CHAR-1 SHALL go to DONE; the index SHALL never exceed NUM_CHAR-1.
REQ-021 WRITE SHALL hold o_wr_valid, o_wr_char, o_wr_x and o_wr_y stable until accepted; on accept it sets shadow[k] <= snapshot[k] and clears o_wr_valid; if k = NUM_CHAR-1 -> DONE, else increments k -> SCAN.
REQ-022 DONE lasts one cycle: it clears the force flag and o_busy, sets o_rd_dv, and returns to IDLE.
REQ-023 Changes to i_characters during a scan SHALL NOT affect the scan in progress; they are detected in IDLE after DONE.
REQ-024 An i_force pulse in any state SHALL set the force flag; a pulse arriving after the scan has started is honoured by the next scan (flag re-set one cycle after DONE clears it if simultaneous).
REQ-025 Cost: an unchanged cell takes 1 cycle; a changed cell takes 2 cycles plus stall cycles.
REQ-026 o_wr_valid SHALL never be asserted outside WRITE.

Reset
REQ-027 With i_rst high, on the clock edge: state = IDLE, o_wr_valid = 0, o_busy = 0, o_rd_dv = 0, outputs o_wr_char/x/y = 0, shadow = 0, index = 0, force flag = 1.
REQ-028 After reset release, the first scan SHALL rewrite all NUM_CHAR cells.
REQ-029 Reset mid-WRITE SHALL drop o_wr_valid at the next edge without completing the write.

Configuration
REQ-030 Macro TEXT_OVERLAY_ATTR_EN, when defined, SHALL add input i_attrs (NUM_CHAR*ATTR_W, same ordering as i_characters) and output o_wr_attr (ATTR_W), and extend the shadow/snapshot so that a cell is changed if its character or its attribute differs; o_wr_attr follows the same timing as o_wr_char.
REQ-031 Without TEXT_OVERLAY_ATTR_EN, neither port exists and no attribute storage is synthesised.

Verification (NUM_CHAR=4, COLUMNS=2, CHAR_W=8, i_wr_ready=1 unless noted)
REQ-032 Reset, i_characters=0x41424344 -> 4 writes: (0,0,0x41), (1,0,0x42), (0,1,0x43), (1,1,0x44); then o_rd_dv=1, o_busy=0.
REQ-033 Then change only cell 2 to 0x5A -> exactly one write (0,1,0x5A); 1 DONE cycle; o_rd_dv low from the cycle after the change until DONE.
REQ-034 Hold i_wr_ready=0 for 5 cycles during a write -> o_wr_valid and the payload stay stable for 5 cycles, then the write is accepted once.
REQ-035 Change i_characters mid-scan -> the current scan completes using the old snapshot; a second scan writes only the newly differing cells.
REQ-036 i_force with no data change -> 4 writes of the unchanged values; i_rst asserted mid-WRITE -> o_wr_valid=0 next cycle, then a full 4-cell rewrite.

Source files
------------

// File: rtl/text_overlay_writer_if.sv
// Write channel from the overlay writer into a character buffer.
// Latency: none (signal bundle only).
// Backpressure: the writer holds wr_valid and the payload until wr_ready.
// Signals:
//   wr_valid  writer -> buffer  write request
//   wr_ready  buffer -> writer  write accepted when wr_valid && wr_ready
//   wr_char   writer -> buffer  character code
//   wr_x      writer -> buffer  column of the cell
//   wr_y      writer -> buffer  row of the cell
//   wr_attr   writer -> buffer  cell attribute (only with TEXT_OVERLAY_ATTR_EN)
// X_W / Y_W must match the column/row widths derived inside the writer.
interface text_overlay_writer_if #(
  parameter int CHAR_W = 8,
  parameter int ATTR_W = 4,
  parameter int X_W    = 4,
  parameter int Y_W    = 5
);
  logic              wr_valid;
  logic              wr_ready;
  logic [CHAR_W-1:0] wr_char;
  logic [X_W-1:0]    wr_x;
  logic [Y_W-1:0]    wr_y;
`ifdef TEXT_OVERLAY_ATTR_EN
  logic [ATTR_W-1:0] wr_attr;
`endif

  modport master (
    output wr_valid,
    input  wr_ready,
    output wr_char,
    output wr_x,
    output wr_y
`ifdef TEXT_OVERLAY_ATTR_EN
    ,
    output wr_attr
`endif
  );

  modport slave (
    input  wr_valid,
    output wr_ready,
    input  wr_char,
    input  wr_x,
    input  wr_y
`ifdef TEXT_OVERLAY_ATTR_EN
    ,
    input  wr_attr
`endif
  );
endinterface

// File: rtl/text_overlay_writer.sv
// Incremental text overlay writer: pushes only changed character cells into a buffer.
// Latency: 1 cycle to start a scan, 1 cycle per unchanged cell, 2 cycles per changed cell, 1 DONE cycle.
// Backpressure: a pending write holds valid and payload stable until wr_ready; the scan stalls meanwhile.
// Ports:
//   i_clk, i_rst    clock, synchronous active-high reset
//   i_characters    NUM_CHAR packed codes, cell 0 in the MSBs
//   i_attrs         NUM_CHAR packed attributes, same ordering (TEXT_OVERLAY_ATTR_EN only)
//   i_force         pulse, rewrite every cell on the next scan
//   wr              write channel (master side)
//   o_busy          scan in progress
//   o_rd_dv         buffer holds the last scanned snapshot, nothing pending
// Optional feature macro: TEXT_OVERLAY_ATTR_EN adds per-cell attributes.
module text_overlay_writer #(
  parameter int NUM_CHAR = 300,
  parameter int COLUMNS  = 16,
  parameter int CHAR_W   = 8,
  parameter int ATTR_W   = 4
) (
  input  logic                       i_clk,
  input  logic                       i_rst,
  input  logic [NUM_CHAR*CHAR_W-1:0] i_characters,
`ifdef TEXT_OVERLAY_ATTR_EN
  input  logic [NUM_CHAR*ATTR_W-1:0] i_attrs,
`endif
  input  logic                       i_force,
  text_overlay_writer_if.master      wr,
  output logic                       o_busy,
  output logic                       o_rd_dv
);

  localparam int ROWS  = (NUM_CHAR + COLUMNS - 1) / COLUMNS;
  localparam int X_W   = (COLUMNS > 1) ? $clog2(COLUMNS) : 1;
  localparam int Y_W   = (ROWS > 1) ? $clog2(ROWS) : 1;
  localparam int IDX_W = (NUM_CHAR > 1) ? $clog2(NUM_CHAR) : 1;

  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_CHAR - 1);
  localparam logic [X_W-1:0]   LAST_COL = X_W'(COLUMNS - 1);

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_SCAN,
    ST_WRITE,
    ST_DONE
  } state_t;

  state_t state, state_nxt;

  logic [IDX_W-1:0]           idx;
  logic [X_W-1:0]             col;
  logic [Y_W-1:0]             row;
  logic [NUM_CHAR*CHAR_W-1:0] shadow_char;
  logic [NUM_CHAR*CHAR_W-1:0] snap_char;
  logic                       force_flag;
  logic                       force_late;

  logic [CHAR_W-1:0]          snap_cell;
  logic [CHAR_W-1:0]          shadow_cell;
  logic                       any_change;
  logic                       cell_diff;

  // FSM strobes consumed by the datapath
  logic start_scan;
  logic load_wr;
  logic accept;
  logic advance;
  logic finish;

  // Bit offset of cell k inside a packed vector of w-bit fields (cell 0 at the top).
  function automatic int cell_lsb(input logic [IDX_W-1:0] k, input int w);
    return w * (NUM_CHAR - 1 - int'(k));
  endfunction

`ifdef TEXT_OVERLAY_ATTR_EN
  logic [NUM_CHAR*ATTR_W-1:0] shadow_attr;
  logic [NUM_CHAR*ATTR_W-1:0] snap_attr;
  logic [ATTR_W-1:0]          snap_acell;
  logic [ATTR_W-1:0]          shadow_acell;
`endif

  always_comb begin
    snap_cell   = snap_char[cell_lsb(idx, CHAR_W) +: CHAR_W];
    shadow_cell = shadow_char[cell_lsb(idx, CHAR_W) +: CHAR_W];
`ifdef TEXT_OVERLAY_ATTR_EN
    snap_acell   = snap_attr[cell_lsb(idx, ATTR_W) +: ATTR_W];
    shadow_acell = shadow_attr[cell_lsb(idx, ATTR_W) +: ATTR_W];
    any_change   = (i_characters != shadow_char) || (i_attrs != shadow_attr);
    cell_diff    = (snap_cell != shadow_cell) || (snap_acell != shadow_acell) || force_flag;
`else
    any_change   = (i_characters != shadow_char);
    cell_diff    = (snap_cell != shadow_cell) || force_flag;
`endif
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state <= ST_IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt  = state;
    start_scan = 1'b0;
    load_wr    = 1'b0;
    accept     = 1'b0;
    advance    = 1'b0;
    finish     = 1'b0;
    case (state)
      ST_IDLE: begin
        if (any_change || force_flag) begin
          start_scan = 1'b1;
          state_nxt  = ST_SCAN;
        end
      end
      ST_SCAN: begin
        if (cell_diff) begin
          load_wr   = 1'b1;
          state_nxt = ST_WRITE;
        end else if (idx == LAST_IDX) begin
          state_nxt = ST_DONE;
        end else begin
          advance = 1'b1;
        end
      end
      ST_WRITE: begin
        if (wr.wr_valid && wr.wr_ready) begin
          accept = 1'b1;
          if (idx == LAST_IDX) begin
            state_nxt = ST_DONE;
          end else begin
            advance   = 1'b1;
            state_nxt = ST_SCAN;
          end
        end
      end
      ST_DONE: begin
        finish    = 1'b1;
        state_nxt = ST_IDLE;
      end
      default: state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      idx         <= '0;
      col         <= '0;
      row         <= '0;
      shadow_char <= '0;
      snap_char   <= '0;
      wr.wr_valid <= 1'b0;
      wr.wr_char  <= '0;
      wr.wr_x     <= '0;
      wr.wr_y     <= '0;
      o_busy      <= 1'b0;
      o_rd_dv     <= 1'b0;
      // Shadow starts at zero, which the buffer need not match: force a full rewrite.
      force_flag  <= 1'b1;
      force_late  <= 1'b0;
`ifdef TEXT_OVERLAY_ATTR_EN
      shadow_attr <= '0;
      snap_attr   <= '0;
      wr.wr_attr  <= '0;
`endif
    end else begin
      if (start_scan) begin
        snap_char <= i_characters;
`ifdef TEXT_OVERLAY_ATTR_EN
        snap_attr <= i_attrs;
`endif
        idx     <= '0;
        col     <= '0;
        row     <= '0;
        o_busy  <= 1'b1;
        o_rd_dv <= 1'b0;
      end

      // Column/row tracked alongside the index so no divider is needed.
      if (advance) begin
        idx <= idx + IDX_W'(1);
        if (col == LAST_COL) begin
          col <= '0;
          row <= row + Y_W'(1);
        end else begin
          col <= col + X_W'(1);
        end
      end

      if (load_wr) begin
        wr.wr_valid <= 1'b1;
        wr.wr_char  <= snap_cell;
        wr.wr_x     <= col;
        wr.wr_y     <= row;
`ifdef TEXT_OVERLAY_ATTR_EN
        wr.wr_attr  <= snap_acell;
`endif
      end

      if (accept) begin
        wr.wr_valid <= 1'b0;
        shadow_char[cell_lsb(idx, CHAR_W) +: CHAR_W] <= snap_cell;
`ifdef TEXT_OVERLAY_ATTR_EN
        shadow_attr[cell_lsb(idx, ATTR_W) +: ATTR_W] <= snap_acell;
`endif
      end

      if (finish) begin
        o_busy  <= 1'b0;
        o_rd_dv <= 1'b1;
      end

      // A force pulse landing on the DONE cycle would be lost by the clear,
      // so it is parked for one cycle and re-applied afterwards.
      force_late <= finish && i_force;
      if (finish) begin
        force_flag <= 1'b0;
      end else if (i_force || force_late) begin
        force_flag <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_text_overlay_writer.sv
module tb_text_overlay_writer;

  logic        i_clk;
  logic        i_rst;
  logic [31:0] i_characters;
  logic        i_force;
  logic        o_busy;
  logic        o_rd_dv;

  int checks;
  int errors;

  // accepted writes as {x, y, char}
  logic [9:0] wlog[$];

  text_overlay_writer_if #(.CHAR_W(8), .ATTR_W(4), .X_W(1), .Y_W(1)) wr_if ();

  text_overlay_writer #(
    .NUM_CHAR(4),
    .COLUMNS (2),
    .CHAR_W  (8),
    .ATTR_W  (4)
  ) dut (
    .i_clk       (i_clk),
    .i_rst       (i_rst),
    .i_characters(i_characters),
`ifdef TEXT_OVERLAY_ATTR_EN
    .i_attrs     (16'h0000),
`endif
    .i_force     (i_force),
    .wr          (wr_if.master),
    .o_busy      (o_busy),
    .o_rd_dv     (o_rd_dv)
  );

  initial i_clk = 1'b0;
  always #5 i_clk = ~i_clk;

  // Record accepted writes; a write may only be pending during a scan.
  always @(negedge i_clk) begin
    if (i_rst === 1'b0 && wr_if.wr_valid === 1'b1) begin
      checks++;
      if (o_busy !== 1'b1) begin
        errors++;
        $display("FAIL valid_outside_scan busy=%b required 1", o_busy);
      end
      if (wr_if.wr_ready === 1'b1)
        wlog.push_back({wr_if.wr_x, wr_if.wr_y, wr_if.wr_char});
    end
  end

  task automatic tick();
    @(posedge i_clk);
    #1;
  endtask

  // Wait for a scan to be running, then for it to finish. ok=0 on timeout.
  task automatic wait_scan(output bit ok);
    int n;
    ok = 1'b0;
    n = 0;
    while (o_busy !== 1'b1 && n < 100) begin tick(); n++; end
    if (o_busy !== 1'b1) return;
    n = 0;
    while (o_rd_dv !== 1'b1 && n < 100) begin tick(); n++; end
    ok = (o_rd_dv === 1'b1);
  endtask

  task automatic test_reset();
    logic [9:0] exp[4];
    bit ok;
    exp[0] = {1'b0, 1'b0, 8'h41};
    exp[1] = {1'b1, 1'b0, 8'h42};
    exp[2] = {1'b0, 1'b1, 8'h43};
    exp[3] = {1'b1, 1'b1, 8'h44};
    i_rst = 1'b1;
    i_characters = 32'h41424344;
    tick();
    tick();
    checks++;
    if ({wr_if.wr_valid, o_busy, o_rd_dv, wr_if.wr_char, wr_if.wr_x, wr_if.wr_y} !== 13'd0) begin
      errors++;
      $display("FAIL reset_state got v=%b b=%b dv=%b c=%h x=%b y=%b required all 0",
               wr_if.wr_valid, o_busy, o_rd_dv, wr_if.wr_char, wr_if.wr_x, wr_if.wr_y);
    end
    wlog.delete();
    i_rst = 1'b0;
    wait_scan(ok);
    checks++;
    if (!ok) begin errors++; $display("FAIL reset_scan_timeout rd_dv=%b required 1", o_rd_dv); end
    checks++;
    if (wlog.size() != 4) begin
      errors++;
      $display("FAIL reset_write_count got %0d required 4", wlog.size());
    end else begin
      for (int i = 0; i < 4; i++) begin
        checks++;
        if (wlog[i] !== exp[i]) begin
          errors++;
          $display("FAIL reset_write%0d got %h required %h", i, wlog[i], exp[i]);
        end
      end
    end
    checks++;
    if (o_busy !== 1'b0) begin errors++; $display("FAIL reset_busy_after got %b required 0", o_busy); end
  endtask

  task automatic test_single_change();
    int lows;
    wlog.delete();
    i_characters = 32'h41425A44;
    lows = 0;
    for (int n = 0; n < 50; n++) begin
      tick();
      if (o_rd_dv === 1'b1) break;
      lows++;
    end
    // start + 2 unchanged + 2 for the write + 1 unchanged, DONE sets rd_dv
    checks++;
    if (lows != 6) begin errors++; $display("FAIL single_rd_dv_low got %0d cycles required 6", lows); end
    checks++;
    if (wlog.size() != 1 || wlog[0] !== {1'b0, 1'b1, 8'h5A}) begin
      errors++;
      $display("FAIL single_write got n=%0d first=%h required n=1 %h", wlog.size(),
               (wlog.size() > 0) ? wlog[0] : 10'h0, {1'b0, 1'b1, 8'h5A});
    end
    checks++;
    if (o_busy !== 1'b0) begin errors++; $display("FAIL single_busy got %b required 0", o_busy); end
  endtask

  task automatic test_stall();
    bit ok;
    int n;
    wlog.delete();
    wr_if.wr_ready = 1'b0;
    i_characters = 32'h30425A44;
    n = 0;
    while (wr_if.wr_valid !== 1'b1 && n < 20) begin tick(); n++; end
    checks++;
    if (wr_if.wr_valid !== 1'b1) begin errors++; $display("FAIL stall_valid_timeout got %b required 1", wr_if.wr_valid); end
    for (int i = 0; i < 5; i++) begin
      tick();
      checks++;
      if ({wr_if.wr_valid, wr_if.wr_x, wr_if.wr_y, wr_if.wr_char} !== {1'b1, 1'b0, 1'b0, 8'h30}) begin
        errors++;
        $display("FAIL stall_hold%0d got v=%b x=%b y=%b c=%h required 1 0 0 30",
                 i, wr_if.wr_valid, wr_if.wr_x, wr_if.wr_y, wr_if.wr_char);
      end
    end
    wr_if.wr_ready = 1'b1;
    wait_scan(ok);
    checks++;
    if (!ok) begin errors++; $display("FAIL stall_scan_timeout rd_dv=%b required 1", o_rd_dv); end
    checks++;
    if (wlog.size() != 1 || wlog[0] !== {1'b0, 1'b0, 8'h30}) begin
      errors++;
      $display("FAIL stall_write got n=%0d required one write of %h", wlog.size(), {1'b0, 1'b0, 8'h30});
    end
  endtask

  task automatic test_mid_scan();
    bit ok;
    logic [9:0] exp[2];
    exp[0] = {1'b1, 1'b0, 8'h43};
    exp[1] = {1'b1, 1'b1, 8'h45};
    wlog.delete();
    i_characters = 32'h31425A44;
    tick();
    tick();
    i_characters = 32'h31435A45;
    wait_scan(ok);
    checks++;
    if (!ok) begin errors++; $display("FAIL mid_first_timeout rd_dv=%b required 1", o_rd_dv); end
    checks++;
    if (wlog.size() != 1 || wlog[0] !== {1'b0, 1'b0, 8'h31}) begin
      errors++;
      $display("FAIL mid_first_write got n=%0d required one write of %h", wlog.size(), {1'b0, 1'b0, 8'h31});
    end
    wlog.delete();
    wait_scan(ok);
    checks++;
    if (!ok) begin errors++; $display("FAIL mid_second_timeout rd_dv=%b required 1", o_rd_dv); end
    checks++;
    if (wlog.size() != 2) begin
      errors++;
      $display("FAIL mid_second_count got %0d required 2", wlog.size());
    end else begin
      for (int i = 0; i < 2; i++) begin
        checks++;
        if (wlog[i] !== exp[i]) begin
          errors++;
          $display("FAIL mid_second_write%0d got %h required %h", i, wlog[i], exp[i]);
        end
      end
    end
  endtask

  task automatic test_force();
    bit ok;
    logic [9:0] exp[4];
    exp[0] = {1'b0, 1'b0, 8'h31};
    exp[1] = {1'b1, 1'b0, 8'h43};
    exp[2] = {1'b0, 1'b1, 8'h5A};
    exp[3] = {1'b1, 1'b1, 8'h45};
    wlog.delete();
    i_force = 1'b1;
    tick();
    i_force = 1'b0;
    wait_scan(ok);
    checks++;
    if (!ok) begin errors++; $display("FAIL force_timeout rd_dv=%b required 1", o_rd_dv); end
    checks++;
    if (wlog.size() != 4) begin
      errors++;
      $display("FAIL force_count got %0d required 4", wlog.size());
    end else begin
      for (int i = 0; i < 4; i++) begin
        checks++;
        if (wlog[i] !== exp[i]) begin
          errors++;
          $display("FAIL force_write%0d got %h required %h", i, wlog[i], exp[i]);
        end
      end
    end
  endtask

  task automatic test_reset_mid_write();
    bit ok;
    int n;
    logic [9:0] exp[4];
    exp[0] = {1'b0, 1'b0, 8'h31};
    exp[1] = {1'b1, 1'b0, 8'h43};
    exp[2] = {1'b0, 1'b1, 8'h5A};
    exp[3] = {1'b1, 1'b1, 8'h45};
    wlog.delete();
    wr_if.wr_ready = 1'b0;
    i_force = 1'b1;
    tick();
    i_force = 1'b0;
    n = 0;
    while (wr_if.wr_valid !== 1'b1 && n < 20) begin tick(); n++; end
    tick();
    i_rst = 1'b1;
    tick();
    checks++;
    if ({wr_if.wr_valid, o_busy} !== 2'b00) begin
      errors++;
      $display("FAIL rst_mid_write got v=%b busy=%b required 0 0", wr_if.wr_valid, o_busy);
    end
    i_rst = 1'b0;
    wr_if.wr_ready = 1'b1;
    wait_scan(ok);
    checks++;
    if (!ok) begin errors++; $display("FAIL rst_rewrite_timeout rd_dv=%b required 1", o_rd_dv); end
    checks++;
    if (wlog.size() != 4) begin
      errors++;
      $display("FAIL rst_rewrite_count got %0d required 4", wlog.size());
    end else begin
      for (int i = 0; i < 4; i++) begin
        checks++;
        if (wlog[i] !== exp[i]) begin
          errors++;
          $display("FAIL rst_rewrite%0d got %h required %h", i, wlog[i], exp[i]);
        end
      end
    end
  endtask

  task automatic test_quiet();
    wlog.delete();
    for (int i = 0; i < 10; i++) tick();
    checks++;
    if (wlog.size() != 0 || o_busy !== 1'b0 || o_rd_dv !== 1'b1) begin
      errors++;
      $display("FAIL quiet got writes=%0d busy=%b rd_dv=%b required 0 0 1", wlog.size(), o_busy, o_rd_dv);
    end
  endtask

  initial begin
    checks = 0;
    errors = 0;
    i_rst = 1'b1;
    i_force = 1'b0;
    i_characters = 32'h0;
    wr_if.wr_ready = 1'b1;
    test_reset();
    test_single_change();
    test_stall();
    test_mid_scan();
    test_force();
    test_reset_mid_write();
    test_quiet();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
